// File: rtl/frame_buf_reader_pkg.sv
// Shared types and defaults for the frame buffer reader and its output FIFO.
package frame_buf_reader_pkg;

    localparam int WORD_W    = 32;
    localparam int DEF_H_RES = 640;
    localparam int DEF_V_RES = 480;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One output buffer entry: 32-bit word plus its frame/line markers.
    typedef struct packed {
        logic              sof;
        logic              eol;
        logic [WORD_W-1:0] data;
    } pix_word_t;

endpackage

// File: rtl/frame_buf_reader_fifo.sv
// Small synchronous FIFO for pixel words; push and pop in the same cycle
// both succeed even when full.
module frame_buf_reader_fifo
    import frame_buf_reader_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  pix_word_t              din,
    input  logic                   pop,
    output pix_word_t              dout,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    pix_word_t      mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           push_ok;
    logic           pop_ok;

    assign pop_ok  = pop && (count != '0);
    assign push_ok = push && ((count != (AW+1)'(DEPTH)) || pop_ok);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/frame_buf_reader.sv
// Reads completed frames out of a double-banked frame buffer and streams
// them as ready/valid words with start-of-frame and end-of-line markers.
module frame_buf_reader
    import frame_buf_reader_pkg::*;
#(
    parameter int H_RES      = DEF_H_RES,
    parameter int V_RES      = DEF_V_RES,
    parameter int ADDR_WIDTH = 20,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  rd_clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  frame_ready,
    input  logic                  buf_sel,
    output logic                  mem_rd_en_n,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [WORD_W-1:0]     mem_data,
    output logic [WORD_W-1:0]     pix_data,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic                  pix_sof,
    output logic                  pix_eol,
    output logic                  busy
);

    localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    localparam logic [XW-1:0]         X_LAST     = XW'(H_RES - 1);
    localparam logic [YW-1:0]         Y_LAST     = YW'(V_RES - 1);
    localparam logic [ADDR_WIDTH-1:0] BANK1_BASE = ADDR_WIDTH'(H_RES * V_RES);

    state_t                  state;
    state_t                  state_nxt;
    logic                    pend;
    logic                    pend_bank;
    logic [ADDR_WIDTH-1:0]   rd_addr;
    logic [XW-1:0]           x;
    logic [YW-1:0]           y;
    logic                    inflight;
    logic                    infl_sof;
    logic                    infl_eol;
    logic                    start;
    logic                    issue;
    logic                    room;
    logic                    last_rd;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_cnt;
    pix_word_t               fifo_din;
    pix_word_t               fifo_dout;

    // Reserve a FIFO slot for every read still in flight so a returning
    // word always has somewhere to land.
    assign room       = (fifo_cnt + CW'(inflight)) < CW'(FIFO_DEPTH);
    assign last_rd    = (x == X_LAST) && (y == Y_LAST);
    assign fifo_empty = (fifo_cnt == '0);

    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        issue     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (enable && pend) begin
                    start     = 1'b1;
                    state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (room) begin
                    issue = 1'b1;
                    if (last_rd)
                        state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (fifo_empty && !inflight) begin
                    if (enable && pend) begin
                        start     = 1'b1;
                        state_nxt = ST_READ;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (reset) begin
            start = 1'b0;
            issue = 1'b0;
        end
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            pend      <= 1'b0;
            pend_bank <= 1'b0;
            rd_addr   <= '0;
            x         <= '0;
            y         <= '0;
            inflight  <= 1'b0;
            infl_sof  <= 1'b0;
            infl_eol  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start) begin
                pend    <= 1'b0;
                rd_addr <= pend_bank ? BANK1_BASE : '0;
                x       <= '0;
                y       <= '0;
            end
            // A new frame_ready wins over the consume above; newest bank kept.
            if (frame_ready) begin
                pend      <= 1'b1;
                pend_bank <= buf_sel;
            end
            if (issue) begin
                rd_addr <= rd_addr + 1'b1;
                if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 1'b1;
                end else begin
                    x <= x + 1'b1;
                end
            end
            inflight <= issue;
            infl_sof <= issue && (x == '0) && (y == '0);
            infl_eol <= issue && (x == X_LAST);
        end
    end

    assign fifo_din = '{sof: infl_sof, eol: infl_eol, data: mem_data};

    frame_buf_reader_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (rd_clk),
        .reset (reset),
        .push  (inflight),
        .din   (fifo_din),
        .pop   (pix_valid && pix_ready),
        .dout  (fifo_dout),
        .count (fifo_cnt)
    );

    assign mem_rd_en_n = ~issue;
    assign mem_addr    = issue ? rd_addr : '0;
    assign pix_valid   = !fifo_empty;
    assign pix_data    = pix_valid ? fifo_dout.data : '0;
    assign pix_sof     = pix_valid && fifo_dout.sof;
    assign pix_eol     = pix_valid && fifo_dout.eol;
    assign busy        = (state != ST_IDLE);

endmodule

// File: tb/tb_frame_buf_reader.sv
// Directed bench for frame_buf_reader on a 4x2 frame; the memory model
// returns the read address as data.
module tb_frame_buf_reader;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int D  = 4;
    localparam int AW = 5;

    logic          rd_clk = 1'b0;
    logic          reset = 1'b1;
    logic          enable = 1'b0;
    logic          frame_ready = 1'b0;
    logic          buf_sel = 1'b0;
    logic          pix_ready = 1'b1;
    logic          mem_rd_en_n;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data;
    logic [31:0]   pix_data;
    logic          pix_valid;
    logic          pix_sof;
    logic          pix_eol;
    logic          busy;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          n_iss = 0;
    int          n_xfer = 0;
    logic        prev_stall = 1'b0;
    logic [33:0] prev_word = '0;
    logic [33:0] xq[$];
    int          cq[$];

    frame_buf_reader #(
        .H_RES      (H),
        .V_RES      (V),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (D)
    ) dut (
        .rd_clk      (rd_clk),
        .reset       (reset),
        .enable      (enable),
        .frame_ready (frame_ready),
        .buf_sel     (buf_sel),
        .mem_rd_en_n (mem_rd_en_n),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .pix_data    (pix_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_sof     (pix_sof),
        .pix_eol     (pix_eol),
        .busy        (busy)
    );

    always #5 rd_clk = ~rd_clk;

    always @(posedge rd_clk) begin
        cyc      <= cyc + 1;
        mem_data <= !mem_rd_en_n ? 32'(mem_addr) : 32'hBAD0_0BAD;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Transfer log, stall-hold check and occupancy bound.
    always @(negedge rd_clk) begin
        if (reset) begin
            n_iss      <= 0;
            n_xfer     <= 0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall)
                chk("stall_hold", 64'({pix_valid, pix_sof, pix_eol, pix_data}), 64'({1'b1, prev_word}));
            if (!mem_rd_en_n) begin
                chk("no_overflow", (n_iss - n_xfer < D) ? 64'd1 : 64'd0, 64'd1);
                n_iss <= n_iss + 1;
            end
            if (pix_valid && pix_ready) begin
                xq.push_back({pix_sof, pix_eol, pix_data});
                cq.push_back(cyc);
                n_xfer <= n_xfer + 1;
            end
            prev_stall <= pix_valid && !pix_ready;
            prev_word  <= {pix_sof, pix_eol, pix_data};
        end
    end

    task automatic clear_log();
        xq.delete();
        cq.delete();
    endtask

    task automatic pulse(input logic sel);
        @(posedge rd_clk); #1;
        frame_ready = 1'b1;
        buf_sel     = sel;
        @(posedge rd_clk); #1;
        frame_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge rd_clk); #1;
        reset = 1'b1;
        repeat (2) @(posedge rd_clk);
        #1 reset = 1'b0;
        clear_log();
    endtask

    task automatic wait_words(input int n, input string tag);
        for (int k = 0; k < 200 && xq.size() < n; k++)
            @(negedge rd_clk);
        if (xq.size() < n)
            chk({tag, "_timeout"}, 64'(xq.size()), 64'(n));
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (!busy && k < 50) begin @(negedge rd_clk); k++; end
        k = 0;
        while (busy && k < 500) begin @(negedge rd_clk); k++; end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    task automatic check_frame(input string tag, input int first, input int n, input bit consec);
        chk({tag, "_count"}, 64'(xq.size()), 64'(n));
        for (int i = 0; i < n && i < xq.size(); i++)
            chk($sformatf("%s_w%0d", tag, i), 64'(xq[i]),
                64'({(i % 8 == 0), (i % 4 == 3), 32'(first + i)}));
        if (consec && xq.size() == n)
            chk({tag, "_gap"}, 64'(cq[n-1] - cq[0]), 64'(n - 1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("rst_valid", 64'(pix_valid), 64'd0);
        chk("rst_rd_en_n", 64'(mem_rd_en_n), 64'd1);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_data", 64'(pix_data), 64'd0);
        chk("rst_sof", 64'(pix_sof), 64'd0);
        chk("rst_eol", 64'(pix_eol), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(posedge rd_clk); #1;
        reset  = 1'b0;
        enable = 1'b1;

        // bank 0, free-flowing
        clear_log();
        pulse(1'b0);
        wait_idle("t1");
        check_frame("t1", 0, 8, 1'b1);
        chk("t1_addr_idle", 64'(mem_addr), 64'd0);
        chk("t1_rd_off", 64'(mem_rd_en_n), 64'd1);

        // bank 1
        clear_log();
        pulse(1'b1);
        wait_idle("t2");
        check_frame("t2", 8, 8, 1'b1);

        // 6-cycle stall after the first word
        clear_log();
        pulse(1'b0);
        wait_words(1, "t3");
        @(posedge rd_clk); #1;
        pix_ready = 1'b0;
        repeat (5) @(posedge rd_clk);
        @(negedge rd_clk);
        chk("t3_rd_off", 64'(mem_rd_en_n), 64'd1);
        chk("t3_valid", 64'(pix_valid), 64'd1);
        @(posedge rd_clk); #1;
        pix_ready = 1'b1;
        wait_idle("t3");
        check_frame("t3", 0, 8, 1'b0);

        // second frame queued mid-frame runs back to back
        clear_log();
        pulse(1'b0);
        repeat (3) @(posedge rd_clk);
        pulse(1'b1);
        wait_idle("t4");
        check_frame("t4", 0, 16, 1'b0);

        // enable dropped mid-frame: finish the frame, then stay idle
        clear_log();
        pulse(1'b0);
        wait_words(3, "t5");
        @(posedge rd_clk); #1;
        enable = 1'b0;
        pulse(1'b1);
        wait_idle("t5");
        check_frame("t5", 0, 8, 1'b0);
        repeat (20) @(negedge rd_clk);
        chk("t5_stay_idle", 64'(busy), 64'd0);
        chk("t5_no_more", 64'(xq.size()), 64'd8);

        // reset mid-frame, then restart cleanly
        do_reset();
        enable = 1'b1;
        pulse(1'b0);
        wait_words(5, "t6");
        @(posedge rd_clk); #1;
        reset = 1'b1;
        @(posedge rd_clk); #1;
        reset = 1'b0;
        @(negedge rd_clk);
        chk("t6_valid", 64'(pix_valid), 64'd0);
        chk("t6_rd_off", 64'(mem_rd_en_n), 64'd1);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_data", 64'(pix_data), 64'd0);
        @(negedge rd_clk);
        chk("t6_stale_ignored", 64'(pix_valid), 64'd0);
        clear_log();
        pulse(1'b0);
        wait_idle("t6");
        check_frame("t6", 0, 8, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/frame_buf_reader.md
FRAME_BUF_READER -- requirements
Module: frame_buf_reader

Interface
REQ-001 Parameter H_RES, default 640: 32-bit words per line.
REQ-002 Parameter V_RES, default 480: lines per frame.
REQ-003 Parameter ADDR_WIDTH, default 20: frame buffer address width; SHALL satisfy 2*H_RES*V_RES <= 2**ADDR_WIDTH.
REQ-004 Parameter FIFO_DEPTH, default 4: output buffer entries, power of two, >= 2.
REQ-005 rd_clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 enable  in  1  high = read frames; low = stop after current frame.
REQ-008 frame_ready  in  1  one-cycle pulse: writer has completed a frame in bank buf_sel.
REQ-009 buf_sel  in  1  bank of completed frame; sampled with frame_ready.
REQ-010 mem_rd_en_n  out  1  active-low frame buffer read enable.
REQ-011 mem_addr  out  ADDR_WIDTH  frame buffer read address.
REQ-012 mem_data  in  32  read data, valid exactly one cycle after mem_rd_en_n low.
REQ-013 pix_data  out  32  output word.
REQ-014 pix_valid  out  1  pix_data/pix_sof/pix_eol valid.
REQ-015 pix_ready  in  1  downstream accepts; transfer = pix_valid & pix_ready.
REQ-016 pix_sof  out  1  first word of frame.
REQ-017 pix_eol  out  1  last word of a line.
REQ-018 busy  out  1  high in any state but IDLE.

Function
REQ-019 FSM states IDLE, READ, DRAIN; single pending-frame flag (pend) plus latched bank (pend_bank).
REQ-020 frame_ready SHALL set pend and load pend_bank from buf_sel in any state; a second pulse before consumption overwrites pend_bank (newest frame wins).
REQ-021 IDLE -> READ when enable & pend: clear pend, base = pend_bank*H_RES*V_RES, x=0, y=0.
REQ-022 READ: issue read (mem_rd_en_n=0, mem_addr=base+y*H_RES+x) only when FIFO occupancy + in-flight reads < FIFO_DEPTH; otherwise mem_rd_en_n=1.
REQ-023 Each issued read advances x; x wraps H_RES-1 -> 0 with y+1; read of x=H_RES-1,y=V_RES-1 moves READ -> DRAIN.
REQ-024 Returned mem_data SHALL be pushed into FIFO with sof = (x==0&&y==0) and eol = (x==H_RES-1) of the issuing read; FIFO SHALL never overflow.
REQ-025 FIFO head drives pix_*; pix_valid = FIFO non-empty; pop on transfer; same-cycle push and pop on full or empty FIFO SHALL both succeed.
REQ-026 pix_data/flags SHALL stay stable while pix_valid & ~pix_ready.
REQ-027 DRAIN -> READ when FIFO empty, no read in flight, enable & pend (back-to-back frame, no idle cycle required); else -> IDLE when FIFO empty and no read in flight.
REQ-028 enable low mid-frame SHALL NOT abort the frame; exactly H_RES*V_RES words SHALL be delivered per started frame.
REQ-029 Sustained throughput with pix_ready held high SHALL be one word per cycle after initial 2-cycle latency (frame start to first pix_valid).

Reset
REQ-030 reset SHALL force: state IDLE, pend=0, FIFO empty, no in-flight read, mem_rd_en_n=1, mem_addr=0, pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, busy=0.
REQ-031 reset mid-frame SHALL discard all buffered and in-flight data; mem_data returning the cycle after reset SHALL be ignored.

Structure
REQ-032 Shared package holds word width (32), FSM state encoding, and default H_RES/V_RES.
REQ-033 Output buffer SHALL be a sub-module frame_buf_reader_fifo (synchronous, 34-bit entries: data+sof+eol, FIFO_DEPTH deep, push/pop/count).

Verification (H_RES=4, V_RES=2, FIFO_DEPTH=4, memory model returns address as data)
REQ-034 reset, enable=1, frame_ready with buf_sel=0, pix_ready=1 -> words 0..7 on consecutive cycles, sof on word 0, eol on words 3 and 7, then IDLE, busy=0.
REQ-035 Same, buf_sel=1 -> words 8..15, same flag positions.
REQ-036 pix_ready low for 6 cycles after first word -> mem_rd_en_n high once 4 entries held, no word lost/duplicated, pix_data stable while stalled.
REQ-037 Second frame_ready (buf_sel=1) during first frame -> 0..7 then 8..15, sof on word 8.
REQ-038 enable dropped after word 2 -> all 8 words delivered, then IDLE despite later frame_ready.
REQ-039 reset asserted after word 4 -> next cycle pix_valid=0, mem_rd_en_n=1; new frame_ready restarts at word 0 with sof.
